mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares the single-port data/program memory between three requesters of the 16-bit core:
//  instruction fetch (F), LDR/STR data port (D) and PSH/POP/JMP/RET stack port (S).
//  Fixed priority D > S > F, with a fetch anti-starvation rule. Multi-cycle access sequencer
//  with a programmable wait-state count. Sits between the Control_Unit-driven datapath and memory.
// PARAMETERS
//  AW            10  memory address width
//  DW            16  data width
//  WAIT_CYCLES   1   extra memory wait states per access (0..15)
//  FETCH_STARVE  4   consecutive non-fetch grants after which a pending fetch wins
// PORTS
//  clk          in   1   system clock, rising edge
//  rst          in   1   asynchronous, active-low reset
//  f_req/d_req/s_req    in  1 each   access request, held high until matching ack
//  d_we, s_we           in  1 each   1 = write (F is read-only)
//  f_addr/d_addr/s_addr in  AW each  request address
//  d_wdata, s_wdata     in  DW each  write data
//  f_ack/d_ack/s_ack    out 1 each   one-cycle completion pulse
//  rdata        out  DW  registered read data, valid in the ack cycle, held until next capture
//  busy         out  1   1 whenever state != IDLE
//  mem_en       out  1   memory enable
//  mem_we       out  1   memory write enable
//  mem_addr     out  AW  memory address
//  mem_wdata    out  DW  memory write data
//  mem_rdata    in   DW  memory read data, valid on the last cycle of the access
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE; all acks, busy, mem_en, mem_we=0; mem_addr, mem_wdata,
//   rdata=0; winner and streak counter cleared. In-flight access is dropped, no ack; requester re-requests.
//  FSM: IDLE -> ACCESS -> WAIT (skipped if WAIT_CYCLES=0) -> DONE -> IDLE.
//  IDLE: if any req, latch winner id, addr, we, wdata at the clock edge; go to ACCESS.
//   Arbitration: D, else S, else F; override: if streak==FETCH_STARVE and f_req, F wins.
//   streak increments (saturating at FETCH_STARVE) on each D/S grant, clears on each F grant.
//  ACCESS (1 cycle): mem_en=1, mem_addr/mem_wdata from latches, mem_we=latched we;
//   wait counter loaded with WAIT_CYCLES.
//  WAIT: mem_en=1, mem_we=0, mem_addr held; decrement each cycle; leave when counter hits 1.
//  rdata captured from mem_rdata on the edge leaving the last ACCESS/WAIT cycle (reads only;
//   writes leave rdata unchanged).
//  DONE (1 cycle): winner's ack=1; mem_en=0; then IDLE.
//  Latency: req seen in IDLE cycle 0 -> ack in cycle 2+WAIT_CYCLES. One grant per transaction;
//   minimum gap between grants is one IDLE cycle.
//  Requester keeping req high in the cycle after ack issues a new request (re-arbitrated).
//  Req deasserted before ack: access still completes and ack still pulses (protocol violation).
//  Requests arriving while busy wait; no queueing beyond the held req lines.
//  Simultaneous reqs resolved only in IDLE; latched inputs ignore changes mid-access.
// TESTING
//  1. Reset mid-WAIT of a D read (WAIT_CYCLES=3) -> no d_ack; all outputs 0; next f_req acked normally.
//  2. f_req alone, f_addr=0x005, mem holds 0xBEEF, WAIT_CYCLES=1 -> f_ack in cycle 3, rdata=0xBEEF, mem_we=0 throughout.
//  3. d_req write d_addr=0x3F0 d_wdata=0x1234, then s_req read 0x3F0 -> mem_we=1 for exactly one
//     cycle; s_ack with rdata=0x1234.
//  4. d_req, s_req, f_req raised together -> ack order D, S, F; one ack per transaction.
//  5. d_req and s_req held continuously, f_req pending -> after 4 D/S grants, F granted 5th;
//     streak resets; pattern repeats.
//  6. WAIT_CYCLES=0 read -> ack 2 cycles after req; WAIT state never entered; busy high exactly 2 cycles.

Source files
------------

// File: rtl/mem_bus_arbiter.sv
// Shared memory port arbiter: D > S > F with fetch anti-starvation,
// plus an ACCESS/WAIT/DONE sequencer with programmable wait states.
module mem_bus_arbiter #(
    parameter int AW           = 10,
    parameter int DW           = 16,
    parameter int WAIT_CYCLES  = 1,
    parameter int FETCH_STARVE = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          f_req,
    input  logic          d_req,
    input  logic          s_req,
    input  logic          d_we,
    input  logic          s_we,
    input  logic [AW-1:0] f_addr,
    input  logic [AW-1:0] d_addr,
    input  logic [AW-1:0] s_addr,
    input  logic [DW-1:0] d_wdata,
    input  logic [DW-1:0] s_wdata,
    output logic          f_ack,
    output logic          d_ack,
    output logic          s_ack,
    output logic [DW-1:0] rdata,
    output logic          busy,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);
    localparam int SW = (FETCH_STARVE < 1) ? 1 : $clog2(FETCH_STARVE + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(FETCH_STARVE);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);
    localparam bit NO_WAIT = (WAIT_CYCLES == 0);
    localparam logic [1:0] ID_F = 2'd0;
    localparam logic [1:0] ID_D = 2'd1;
    localparam logic [1:0] ID_S = 2'd2;

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

    state_t         r_state;
    state_t         w_next;
    logic [1:0]     r_win;
    logic [AW-1:0]  r_addr;
    logic           r_we;
    logic [DW-1:0]  r_wdata;
    logic [3:0]     r_wcnt;
    logic [SW-1:0]  r_streak;
    logic [DW-1:0]  r_rdata;

    logic           w_any;
    logic           w_last;
    logic [1:0]     w_pick;
    logic [AW-1:0]  w_addr;
    logic           w_we;
    logic [DW-1:0]  w_wdata;

    assign w_any     = f_req | d_req | s_req;
    assign rdata     = r_rdata;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    // pick the winner: a starved fetch first, otherwise D > S > F
    always_comb begin
        w_pick  = ID_F;
        w_addr  = f_addr;
        w_we    = 1'b0;
        w_wdata = '0;
        if (r_streak == STARVE_MAX && f_req) begin
            w_pick = ID_F;
        end else if (d_req) begin
            w_pick  = ID_D;
            w_addr  = d_addr;
            w_we    = d_we;
            w_wdata = d_wdata;
        end else if (s_req) begin
            w_pick  = ID_S;
            w_addr  = s_addr;
            w_we    = s_we;
            w_wdata = s_wdata;
        end
    end

    // next state, memory strobes and completion pulses
    always_comb begin
        w_next = r_state;
        w_last = 1'b0;
        busy   = (r_state != IDLE);
        mem_en = 1'b0;
        mem_we = 1'b0;
        f_ack  = 1'b0;
        d_ack  = 1'b0;
        s_ack  = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (w_any) w_next = ACCESS;
            end
            ACCESS: begin
                mem_en = 1'b1;
                mem_we = r_we;
                w_last = NO_WAIT;
                w_next = NO_WAIT ? DONE : WAIT;
            end
            WAIT: begin
                mem_en = 1'b1;
                if (r_wcnt <= 4'd1) begin
                    w_last = 1'b1;
                    w_next = DONE;
                end
            end
            DONE: begin
                f_ack  = (r_win == ID_F);
                d_ack  = (r_win == ID_D);
                s_ack  = (r_win == ID_S);
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next;
    end

    // request latch, fetch streak and wait-state counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_win    <= ID_F;
            r_addr   <= '0;
            r_we     <= 1'b0;
            r_wdata  <= '0;
            r_wcnt   <= '0;
            r_streak <= '0;
        end else begin
            if (r_state == IDLE && w_any) begin
                r_win   <= w_pick;
                r_addr  <= w_addr;
                r_we    <= w_we;
                r_wdata <= w_wdata;
                if (w_pick == ID_F)
                    r_streak <= '0;
                else if (r_streak != STARVE_MAX)
                    r_streak <= r_streak + SW'(1);
            end
            if (r_state == ACCESS)
                r_wcnt <= WAIT_LOAD;
            else if (r_state == WAIT)
                r_wcnt <= r_wcnt - 4'd1;
        end
    end

    // read data is taken on the edge that ends the last memory cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            r_rdata <= '0;
        else if (w_last && !r_we)
            r_rdata <= mem_rdata;
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: directed scenarios plus random traffic
// checked cycle by cycle against a transaction-level reference model.
module tb_mem_bus_arbiter;
    localparam int AW = 10;
    localparam int DW = 16;
    localparam int W1 = 1;
    localparam int STARVE = 4;
    localparam int ID_F = 0;
    localparam int ID_D = 1;
    localparam int ID_S = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // main DUT, WAIT_CYCLES=1
    logic f_req, d_req, s_req, d_we, s_we;
    logic [AW-1:0] f_addr, d_addr, s_addr, m_addr;
    logic [DW-1:0] d_wdata, s_wdata, rdata, m_wdata, m_rdata;
    logic f_ack, d_ack, s_ack, busy, m_en, m_we;

    // WAIT_CYCLES=0 DUT (a_) and WAIT_CYCLES=3 DUT (b_)
    logic a_f_req, a_d_req, a_f_ack, a_d_ack, a_s_ack, a_busy, a_en, a_we;
    logic [AW-1:0] a_f_addr, a_d_addr, a_addr;
    logic [DW-1:0] a_rdata, a_wdata, a_mrd;
    logic b_f_req, b_d_req, b_f_ack, b_d_ack, b_s_ack, b_busy, b_en, b_we;
    logic [AW-1:0] b_f_addr, b_d_addr, b_addr;
    logic [DW-1:0] b_rdata, b_wdata, b_mrd;

    mem_bus_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(W1), .FETCH_STARVE(STARVE)) u1 (
        .clk(clk), .rst(rst_n),
        .f_req(f_req), .d_req(d_req), .s_req(s_req), .d_we(d_we), .s_we(s_we),
        .f_addr(f_addr), .d_addr(d_addr), .s_addr(s_addr),
        .d_wdata(d_wdata), .s_wdata(s_wdata),
        .f_ack(f_ack), .d_ack(d_ack), .s_ack(s_ack), .rdata(rdata), .busy(busy),
        .mem_en(m_en), .mem_we(m_we), .mem_addr(m_addr), .mem_wdata(m_wdata),
        .mem_rdata(m_rdata));

    mem_bus_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(0), .FETCH_STARVE(STARVE)) u0 (
        .clk(clk), .rst(rst_n),
        .f_req(a_f_req), .d_req(a_d_req), .s_req(1'b0), .d_we(1'b0), .s_we(1'b0),
        .f_addr(a_f_addr), .d_addr(a_d_addr), .s_addr('0),
        .d_wdata('0), .s_wdata('0),
        .f_ack(a_f_ack), .d_ack(a_d_ack), .s_ack(a_s_ack), .rdata(a_rdata),
        .busy(a_busy), .mem_en(a_en), .mem_we(a_we), .mem_addr(a_addr),
        .mem_wdata(a_wdata), .mem_rdata(a_mrd));

    mem_bus_arbiter #(.AW(AW), .DW(DW), .WAIT_CYCLES(3), .FETCH_STARVE(STARVE)) u3 (
        .clk(clk), .rst(rst_n),
        .f_req(b_f_req), .d_req(b_d_req), .s_req(1'b0), .d_we(1'b0), .s_we(1'b0),
        .f_addr(b_f_addr), .d_addr(b_d_addr), .s_addr('0),
        .d_wdata('0), .s_wdata('0),
        .f_ack(b_f_ack), .d_ack(b_d_ack), .s_ack(b_s_ack), .rdata(b_rdata),
        .busy(b_busy), .mem_en(b_en), .mem_we(b_we), .mem_addr(b_addr),
        .mem_wdata(b_wdata), .mem_rdata(b_mrd));

    function automatic logic [DW-1:0] init_val(logic [AW-1:0] a);
        return (a == 10'h005) ? 16'hBEEF : ({a[5:0], a} ^ 16'h5A3C);
    endfunction

    // memory device behind the main DUT
    logic [DW-1:0] mem [1024];
    bit            wv  [1024];
    always @(posedge clk)
        if (m_en && m_we) begin
            mem[m_addr] <= m_wdata;
            wv[m_addr]  <= 1'b1;
        end
    assign m_rdata = wv[m_addr] ? mem[m_addr] : init_val(m_addr);
    assign a_mrd   = {6'h15, a_addr};
    assign b_mrd   = {6'h15, b_addr};

    // reference model state
    logic [DW-1:0] ref_mem [1024];
    int cyc = 0, free_at = 0, g_cycle = -100, g_id = 0, streak = 0;
    bit g_we = 0;
    logic [AW-1:0] g_addr = '0;
    logic [DW-1:0] g_wd = '0, g_data = '0, last_rd = '0;
    int mode = 0;
    int we_cnt = 0;
    int ack_log[$];

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [AW-1:0] rnd_addr();
        return ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
    endfunction

    // one grant decision per free IDLE cycle, from the arbitration rules
    task automatic arbitrate();
        int id;
        if (cyc < free_at || !(f_req || d_req || s_req)) return;
        if (streak == STARVE && f_req) id = ID_F;
        else if (d_req) id = ID_D;
        else if (s_req) id = ID_S;
        else id = ID_F;
        g_cycle = cyc;
        g_id = id;
        if (id == ID_D) begin g_addr = d_addr; g_we = d_we; g_wd = d_wdata; end
        else if (id == ID_S) begin g_addr = s_addr; g_we = s_we; g_wd = s_wdata; end
        else begin g_addr = f_addr; g_we = 1'b0; g_wd = '0; end
        if (g_we) ref_mem[g_addr] = g_wd;
        g_data = ref_mem[g_addr];
        free_at = cyc + 3 + W1;
        if (id == ID_F) streak = 0;
        else if (streak < STARVE) streak++;
    endtask

    task automatic step();
        int rel;
        arbitrate();
        @(negedge clk);
        cyc++;
        rel = cyc - g_cycle;
        if (rel == 2 + W1 && !g_we) last_rd = g_data;
        chk("busy", busy, rel >= 1 && rel <= 2 + W1);
        chk("mem_en", m_en, rel >= 1 && rel <= 1 + W1);
        chk("mem_we", m_we, rel == 1 && g_we);
        chk("f_ack", f_ack, rel == 2 + W1 && g_id == ID_F);
        chk("d_ack", d_ack, rel == 2 + W1 && g_id == ID_D);
        chk("s_ack", s_ack, rel == 2 + W1 && g_id == ID_S);
        chk("rdata", rdata, last_rd);
        if (rel >= 1 && rel <= 1 + W1) chk("mem_addr", m_addr, g_addr);
        if (rel == 1 && g_we) chk("mem_wdata", m_wdata, g_wd);
        we_cnt += int'(m_we);
        if (d_ack) ack_log.push_back(ID_D);
        if (s_ack) ack_log.push_back(ID_S);
        if (f_ack) ack_log.push_back(ID_F);
        if (mode == 0) begin
            if (f_ack) f_req = 0;
            if (d_ack) d_req = 0;
            if (s_ack) s_req = 0;
        end else if (mode == 2) begin
            if (f_ack || !f_req) begin
                f_req = ($urandom_range(0, 2) == 0);
                f_addr = rnd_addr();
            end
            if (d_ack || !d_req) begin
                d_req = ($urandom_range(0, 2) == 0);
                d_addr = rnd_addr(); d_we = 1'($urandom); d_wdata = DW'($urandom);
            end
            if (s_ack || !s_req) begin
                s_req = ($urandom_range(0, 2) == 0);
                s_addr = rnd_addr(); s_we = 1'($urandom); s_wdata = DW'($urandom);
            end
        end
    endtask

    initial begin
        int k, lat, busy_n, en_n;
        bit dseen;
        int exp5 [10];
        exp5 = '{ID_D, ID_D, ID_D, ID_D, ID_F, ID_D, ID_D, ID_D, ID_D, ID_F};
        f_req = 0; d_req = 0; s_req = 0; d_we = 0; s_we = 0;
        f_addr = '0; d_addr = '0; s_addr = '0; d_wdata = '0; s_wdata = '0;
        a_f_req = 0; a_d_req = 0; a_f_addr = '0; a_d_addr = '0;
        b_f_req = 0; b_d_req = 0; b_f_addr = '0; b_d_addr = '0;
        for (int i = 0; i < 1024; i++) ref_mem[i] = init_val(AW'(i));

        repeat (3) @(negedge clk);
        chk("rst_busy", busy, 0);
        chk("rst_en", m_en, 0);
        chk("rst_we", m_we, 0);
        chk("rst_addr", m_addr, 0);
        chk("rst_wdata", m_wdata, 0);
        chk("rst_rdata", rdata, 0);
        chk("rst_acks", {f_ack, d_ack, s_ack}, 0);
        rst_n = 1;
        @(negedge clk);

        // reset in the middle of a WAIT_CYCLES=3 data read
        b_d_req = 1; b_d_addr = 10'h077;
        @(negedge clk);
        @(negedge clk);
        chk("t1_busy_wait", b_busy, 1);
        chk("t1_en_wait", b_en, 1);
        rst_n = 0;
        #1;
        chk("t1_rst_busy", b_busy, 0);
        chk("t1_rst_en", b_en, 0);
        chk("t1_rst_we", b_we, 0);
        chk("t1_rst_addr", b_addr, 0);
        chk("t1_rst_wdata", b_wdata, 0);
        chk("t1_rst_rdata", b_rdata, 0);
        chk("t1_rst_dack", b_d_ack, 0);
        b_d_req = 0;
        @(negedge clk);
        rst_n = 1;
        b_f_req = 1; b_f_addr = 10'h0AB;
        lat = -1; dseen = 0;
        for (k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (b_d_ack) dseen = 1;
            if (b_f_ack && lat < 0) begin lat = k; b_f_req = 0; end
        end
        chk("t1_no_dack", dseen, 0);
        chk("t1_f_lat", lat, 5);
        chk("t1_rdata", b_rdata, {6'h15, 10'h0AB});

        // zero wait states
        a_f_req = 1; a_f_addr = 10'h123;
        lat = -1; busy_n = 0; en_n = 0;
        for (k = 1; k <= 10; k++) begin
            @(negedge clk);
            busy_n += int'(a_busy);
            en_n += int'(a_en);
            if (a_f_ack && lat < 0) begin lat = k; a_f_req = 0; end
        end
        chk("t6_lat", lat, 2);
        chk("t6_busy_cycles", busy_n, 2);
        chk("t6_en_cycles", en_n, 1);
        chk("t6_rdata", a_rdata, {6'h15, 10'h123});

        // single fetch, WAIT_CYCLES=1
        mode = 0;
        step();
        f_req = 1; f_addr = 10'h005;
        we_cnt = 0; lat = -1;
        for (k = 1; k <= 20 && lat < 0; k++) begin
            step();
            if (ack_log.size() > 0) lat = k;
        end
        chk("t2_lat", lat, 3);
        chk("t2_rdata", rdata, 16'hBEEF);
        chk("t2_no_we", we_cnt, 0);
        step();

        // write by D then read back by S
        ack_log.delete();
        d_req = 1; d_we = 1; d_addr = 10'h3F0; d_wdata = 16'h1234;
        s_req = 1; s_we = 0; s_addr = 10'h3F0;
        we_cnt = 0;
        for (k = 0; k < 30 && ack_log.size() < 2; k++) step();
        chk("t3_we_cycles", we_cnt, 1);
        chk("t3_order0", ack_log.size() > 0 ? ack_log[0] : -1, ID_D);
        chk("t3_order1", ack_log.size() > 1 ? ack_log[1] : -1, ID_S);
        chk("t3_rdata", rdata, 16'h1234);
        d_we = 0;
        step();

        // all three at once
        ack_log.delete();
        d_req = 1; d_addr = 10'h010;
        s_req = 1; s_addr = 10'h011;
        f_req = 1; f_addr = 10'h012;
        for (k = 0; k < 40 && ack_log.size() < 3; k++) step();
        repeat (6) step();
        chk("t4_count", ack_log.size(), 3);
        chk("t4_first", ack_log.size() > 0 ? ack_log[0] : -1, ID_D);
        chk("t4_second", ack_log.size() > 1 ? ack_log[1] : -1, ID_S);
        chk("t4_third", ack_log.size() > 2 ? ack_log[2] : -1, ID_F);

        // fetch anti-starvation with D and S held
        ack_log.delete();
        mode = 1;
        d_req = 1; s_req = 1; f_req = 1;
        for (k = 0; k < 100 && ack_log.size() < 10; k++) step();
        d_req = 0; s_req = 0; f_req = 0;
        mode = 0;
        for (int i = 0; i < 10; i++)
            chk($sformatf("t5_grant%0d", i), ack_log.size() > i ? ack_log[i] : -1, exp5[i]);
        repeat (6) step();

        // random traffic against the model
        mode = 2;
        repeat (3000) step();
        mode = 0;
        f_req = 0; d_req = 0; s_req = 0;
        repeat (8) step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
